serial_subtractor: RTL

- Bit-serial, multi-cycle subtractor. It computes A - B - Bin on unsigned DATA_WIDTH operands, one bit per clock, LSB first, using a single borrow-ripple cell and a registered borrow.
- It is the inverse-direction companion to the scalable ripple adder in the arithmetic library.
- It serves area-constrained datapaths that accept DATA_WIDTH-cycle latency, with a start/busy/done handshake.

---
 rtl/serial_subtractor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin subtractor with start/busy/done handshake
//
// Computes {Bout, Diff} = {1'b0, A} - {1'b0, B} - Bin, one bit per clock,
// LSB first, through a single borrow-ripple cell and a registered borrow.
// An accepted start costs DATA_WIDTH edges of RUN followed by one DONE cycle.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request, accepted whenever busy=0 (IDLE or DONE)
//   A     - minuend, captured on an accepted start
//   B     - subtrahend, captured on an accepted start
//   Bin   - borrow-in, captured on an accepted start
//   busy  - high while a subtraction is in progress
//   done  - one-cycle pulse; Diff and Bout valid
//   Diff  - A - B - Bin modulo 2^DATA_WIDTH, updated only on completion
//   Bout  - borrow-out, 1 when A < B + Bin

module serial_subtractor #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Bin,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Diff,
    output logic                  Bout
);

    // A one-bit counter is kept even for DATA_WIDTH=1 so every vector is legal.
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_borrow;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_res;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_diff;
    logic                  r_bout;

    logic                  w_a;
    logic                  w_b;
    logic                  w_d;
    logic                  w_br_next;
    logic [DATA_WIDTH-1:0] w_res_next;

    // Single borrow-ripple cell operating on bit r_cnt.
    always_comb begin
        w_a        = r_a[r_cnt];
        w_b        = r_b[r_cnt];
        w_d        = w_a ^ w_b ^ r_borrow;
        w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
        w_res_next = r_res;
        // The completion edge loads the merged vector straight into r_diff,
        // so the partial result in r_res never reaches the Diff port.
        w_res_next[r_cnt] = w_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a new start exactly like IDLE, giving
                // back-to-back operation at DATA_WIDTH+1 cycles per result.
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= Bin;
                        r_cnt    <= '0;
                        r_res    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end

                // start, A, B and Bin are deliberately not looked at here.
                S_RUN: begin
                    r_res    <= w_res_next;
                    r_borrow <= w_br_next;
                    if (r_cnt == LAST_BIT) begin
                        r_diff  <= w_res_next;
                        r_bout  <= w_br_next;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Diff = r_diff;
    assign Bout = r_bout;

endmodule
